ram2_sram_emu: RTL and testbench
================================

Name: ram2_sram_emu

Overview:
- Synthesizable responder for the Ram2 external-SRAM bus (addr/data/OE/WE/EN, all control active-low), driven by the existing Ram2 controller.
- Backed by an internal word array; replaces the physical chip for simulation and FPGA-internal bring-up.
- Provides configurable read latency, write commit on the WE rising edge, bus-conflict detection, a preload port for boot images and access counters.
- Sits at the board-pin boundary in place of the SRAM.

Parameters:
- DEPTH_W, 10, number of low address bits decoded; array depth 2^DEPTH_W words.
- RD_LAT, 1, extra cycles, 0..7, between a read being recognised and data being driven.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- ram_addr  in  16  bus address; only bits [DEPTH_W-1:0] decoded, upper bits ignored (aliasing).
- ram_data  inout  16  bus data; driven only when drive_en=1, else high-Z.
- ram_oe  in  1  output enable, active low.
- ram_we  in  1  write enable, active low.
- ram_en  in  1  chip enable, active low.
- preload_we  in  1  preload request.
- preload_addr  in  16  preload address, low DEPTH_W bits used.
- preload_data  in  16  preload word.
- preload_ack  out  1  one-cycle pulse: preload accepted.
- drive_en  out  1  emulator currently driving ram_data.
- bus_conflict  out  1  sticky: OE and WE both low while EN low.
- rd_cnt  out  16  completed reads, wraps ffff->0000.
- wr_cnt  out  16  committed writes, wraps ffff->0000.
- state_out  out  3  current FSM state, for debug.

Behaviour:
- Reset (async, rst=1): state IDLE, latency counter 0, drive register 0, preload_ack 0, bus_conflict 0, rd_cnt 0, wr_cnt 0. Array contents are not reset. Reset mid-read releases the bus immediately. Reset mid-write drops the pending write; no commit occurs.
- Bus inputs are sampled on posedge clk.
- drive_en is the registered drive flag AND ~ram_oe AND ~ram_en (combinational gate), so the bus is released in the same cycle OE or EN rises.
- ram_data = drive_en ? rd_q : 16'hzzzz.
- State encoding: IDLE=0, RD_WAIT=1, RD_DRIVE=2, WR_ARMED=3.
- Conflict check, evaluated first in every state: if ram_en=0 and ram_oe=0 and ram_we=0, then:
  - set bus_conflict (cleared only by rst);
  - clear the drive register;
  - discard any pending write;
  - go to IDLE.
- IDLE:
  - en=0, oe=0, we=1: if RD_LAT=0, load rd_q from mem[addr] and go to RD_DRIVE. Otherwise load counter with RD_LAT-1 and go to RD_WAIT.
  - en=0, we=0, oe=1: latch addr/data into wr_addr/wr_data and go to WR_ARMED.
  - Otherwise stay in IDLE.
- RD_WAIT:
  - If oe=1 or en=1, abort to IDLE; rd_cnt unchanged.
  - Else if counter=0, load rd_q from mem[addr], set the drive register, rd_cnt+1, go to RD_DRIVE.
  - Else decrement the counter.
- RD_DRIVE:
  - While oe=0 and en=0, reload rd_q from mem[addr] every cycle. An address change appears on the bus 1 cycle later; no new latency penalty and no extra rd_cnt increment.
  - On oe=1 or en=1, clear the drive register and go to IDLE.
  - When RD_LAT=0, entry from IDLE also sets the drive register and increments rd_cnt.
- WR_ARMED:
  - While we=0 and en=0, re-latch wr_addr/wr_data every cycle (last sampled value wins).
  - When we is sampled 1 with en=0: write mem[wr_addr] <= wr_data, wr_cnt+1, go to IDLE.
  - If en is sampled 1 first: abort, no write, go to IDLE.
- Write data and address are the values sampled in the last cycle with we=0, i.e. before the rising edge.
- Preload:
  - Accepted only when state=IDLE, ram_en=1 and preload_we=1. Then mem[preload_addr] <= preload_data and preload_ack=1 for that cycle.
  - If not accepted, preload_ack=0. The requester holds preload_we until it sees ack.
  - Preload never changes rd_cnt or wr_cnt.
- Read-after-write: a commit in cycle N is visible to a read loaded in cycle N+1 or later.
- Simultaneous IDLE-exit and preload cannot occur, because preload requires en=1.

Test Plan:
- Reset, then preload 0x0005=0xBEEF, hold preload_we → ack pulse 1 cycle later, no counter change. With RD_LAT=1, en=0/oe=0/addr=0x0005 → ram_data=0xBEEF on the 2nd posedge after OE sampled low; rd_cnt=1. Raise OE → bus high-Z in the same cycle.
- Write: en=0, we=0, addr=0x0012, data=0x1234 for 2 cycles, then we=1 → wr_cnt=1. Read 0x0012 → 0x1234. Read 0x0412 (DEPTH_W=10) → 0x1234 (aliasing).
- Write aborted: we=0 with data=0x5555, then en=1 before we rises → wr_cnt unchanged, mem[addr] keeps its old value.
- Conflict: en=0, oe=0, we=0 for 1 cycle → bus_conflict=1 and stays 1, drive_en=0, no write. Only rst clears it.
- Preload rejected: preload_we=1 while en=0 → ack=0 and no array change until en=1 and state=IDLE, then ack=1.
- Wrap and reset: force wr_cnt to 0xFFFF via 65535 writes, then one more → 0x0000. Assert rst mid-RD_WAIT → drive_en=0 immediately, state=0, counters cleared.

Source files
------------

// File: rtl/ram2_sram_emu.sv
// rtl/ram2_sram_emu.sv - Ram2 external-SRAM bus responder backed by an internal word array
module ram2_sram_emu #(
    parameter int DEPTH_W = 10,
    parameter int RD_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ram_addr,
    inout  wire  [15:0] ram_data,
    input  logic        ram_oe,
    input  logic        ram_we,
    input  logic        ram_en,
    input  logic        preload_we,
    input  logic [15:0] preload_addr,
    input  logic [15:0] preload_data,
    output logic        preload_ack,
    output logic        drive_en,
    output logic        bus_conflict,
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt,
    output logic [2:0]  state_out
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_WAIT  = 3'd1,
        RD_DRIVE = 3'd2,
        WR_ARMED = 3'd3
    } state_t;

    localparam int         DEPTH    = 1 << DEPTH_W;
    localparam logic [2:0] LAT_INIT = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

    logic [15:0] mem [DEPTH];

    state_t              state_q, state_d;
    logic [2:0]          lat_q, lat_d;
    logic                drive_q, drive_d;
    logic [15:0]         rd_q, rd_d;
    logic [DEPTH_W-1:0]  wr_addr_q, wr_addr_d;
    logic [15:0]         wr_data_q, wr_data_d;
    logic                ack_q, ack_d;
    logic                conflict_q, conflict_d;
    logic [15:0]         rd_cnt_q, rd_cnt_d;
    logic [15:0]         wr_cnt_q, wr_cnt_d;

    logic                mem_we;
    logic [DEPTH_W-1:0]  mem_waddr;
    logic [15:0]         mem_wdata;
    logic [DEPTH_W-1:0]  bus_idx;
    logic                rd_req, wr_req;

    assign bus_idx = ram_addr[DEPTH_W-1:0];
    assign rd_req  = ~ram_en & ~ram_oe;
    assign wr_req  = ~ram_en & ~ram_we;

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        drive_d    = drive_q;
        rd_d       = rd_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        ack_d      = 1'b0;
        conflict_d = conflict_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_addr_q;
        mem_wdata  = wr_data_q;

        if (rd_req && wr_req) begin
            conflict_d = 1'b1;
            drive_d    = 1'b0;
            state_d    = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rd_req) begin
                        if (RD_LAT == 0) begin
                            rd_d     = mem[bus_idx];
                            drive_d  = 1'b1;
                            rd_cnt_d = rd_cnt_q + 16'd1;
                            state_d  = RD_DRIVE;
                        end else begin
                            lat_d   = LAT_INIT;
                            state_d = RD_WAIT;
                        end
                    end else if (wr_req) begin
                        wr_addr_d = bus_idx;
                        wr_data_d = ram_data;
                        state_d   = WR_ARMED;
                    end else if (ram_en && preload_we) begin
                        mem_we    = 1'b1;
                        mem_waddr = preload_addr[DEPTH_W-1:0];
                        mem_wdata = preload_data;
                        ack_d     = 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (!rd_req) begin
                        state_d = IDLE;
                    end else if (lat_q == 3'd0) begin
                        rd_d     = mem[bus_idx];
                        drive_d  = 1'b1;
                        rd_cnt_d = rd_cnt_q + 16'd1;
                        state_d  = RD_DRIVE;
                    end else begin
                        lat_d = lat_q - 3'd1;
                    end
                end
                RD_DRIVE: begin
                    // Streaming reads: follow address changes without re-paying latency.
                    if (rd_req) begin
                        rd_d = mem[bus_idx];
                    end else begin
                        drive_d = 1'b0;
                        state_d = IDLE;
                    end
                end
                WR_ARMED: begin
                    if (ram_en) begin
                        state_d = IDLE;
                    end else if (ram_we) begin
                        mem_we   = 1'b1;
                        wr_cnt_d = wr_cnt_q + 16'd1;
                        state_d  = IDLE;
                    end else begin
                        wr_addr_d = bus_idx;
                        wr_data_d = ram_data;
                    end
                end
                default: begin
                    drive_d = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lat_q      <= 3'd0;
            drive_q    <= 1'b0;
            rd_q       <= 16'd0;
            wr_addr_q  <= '0;
            wr_data_q  <= 16'd0;
            ack_q      <= 1'b0;
            conflict_q <= 1'b0;
            rd_cnt_q   <= 16'd0;
            wr_cnt_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            drive_q    <= drive_d;
            rd_q       <= rd_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            ack_q      <= ack_d;
            conflict_q <= conflict_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    // Array is not reset; gating with rst drops a commit that coincides with reset.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign drive_en     = drive_q & ~ram_oe & ~ram_en;
    assign ram_data     = drive_en ? rd_q : 16'hzzzz;
    assign preload_ack  = ack_q;
    assign bus_conflict = conflict_q;
    assign rd_cnt       = rd_cnt_q;
    assign wr_cnt       = wr_cnt_q;
    assign state_out    = state_q;

endmodule

// File: tb/tb_ram2_sram_emu.sv
// tb/tb_ram2_sram_emu.sv - self-checking bench for ram2_sram_emu
module tb_ram2_sram_emu;

    localparam int DEPTH_W = 10;
    localparam int RD_LAT  = 1;
    localparam int DEPTH   = 1 << DEPTH_W;
    localparam int EXP_LAT = (RD_LAT == 0) ? 1 : RD_LAT + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ram_addr;
    wire  [15:0] ram_data;
    logic        ram_oe, ram_we, ram_en, preload_we;
    logic [15:0] preload_addr, preload_data;
    logic        preload_ack, drive_en, bus_conflict;
    logic [15:0] rd_cnt, wr_cnt;
    logic [2:0]  state_out;
    logic        tb_drv;
    logic [15:0] tb_data;

    always #5 clk = ~clk;
    assign ram_data = tb_drv ? tb_data : 16'hzzzz;

    ram2_sram_emu #(.DEPTH_W(DEPTH_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_oe(ram_oe), .ram_we(ram_we), .ram_en(ram_en),
        .preload_we(preload_we), .preload_addr(preload_addr), .preload_data(preload_data),
        .preload_ack(preload_ack), .drive_en(drive_en), .bus_conflict(bus_conflict),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .state_out(state_out)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] mdl [DEPTH];
    bit          known [DEPTH];
    logic [15:0] m_rd, m_wr;

    typedef struct {
        int          op;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp_data;
        logic [15:0] exp_rd;
        logic [15:0] exp_wr;
    } vec_t;
    vec_t tbl [9];

    function automatic int idx(input logic [15:0] a);
        return int'(a) % DEPTH;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        ram_en = 1'b1; ram_oe = 1'b1; ram_we = 1'b1; tb_drv = 1'b0;
    endtask

    task automatic op_read(input string name, input logic [15:0] a, output logic [15:0] d);
        int lat;
        bit ok;
        logic [15:0] exp;
        exp = mdl[idx(a)];
        @(negedge clk);
        ram_addr = a; ram_en = 1'b0; ram_oe = 1'b0; ram_we = 1'b1;
        lat = 0; ok = 1'b0;
        for (int i = 0; i < RD_LAT + 4 && !ok; i++) begin
            @(negedge clk);
            lat++;
            ok = drive_en;
        end
        d = ram_data;
        m_rd = m_rd + 16'd1;
        chk({name, "_drive"}, 32'(ok), 32'd1);
        chk({name, "_lat"}, 32'(lat), 32'(EXP_LAT));
        chk({name, "_data"}, 32'(d), 32'(exp));
        ram_oe = 1'b1;
        #1 chk({name, "_release"}, 32'(drive_en), 32'd0);
        @(negedge clk);
        ram_en = 1'b1;
        chk({name, "_rdcnt"}, 32'(rd_cnt), 32'(m_rd));
    endtask

    task automatic op_write(input string name, input logic [15:0] a, input logic [15:0] d, input int hold);
        @(negedge clk);
        ram_addr = a; tb_data = d; tb_drv = 1'b1;
        ram_en = 1'b0; ram_we = 1'b0; ram_oe = 1'b1;
        repeat (hold) @(negedge clk);
        ram_we = 1'b1; tb_drv = 1'b0;
        @(negedge clk);
        ram_en = 1'b1;
        mdl[idx(a)] = d; known[idx(a)] = 1'b1;
        m_wr = m_wr + 16'd1;
        chk({name, "_wrcnt"}, 32'(wr_cnt), 32'(m_wr));
    endtask

    task automatic op_abort(input string name, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        ram_addr = a; tb_data = d; tb_drv = 1'b1;
        ram_en = 1'b0; ram_we = 1'b0; ram_oe = 1'b1;
        @(negedge clk);
        ram_en = 1'b1;
        @(negedge clk);
        ram_we = 1'b1; tb_drv = 1'b0;
        chk({name, "_wrcnt"}, 32'(wr_cnt), 32'(m_wr));
    endtask

    task automatic op_preload(input string name, input logic [15:0] a, input logic [15:0] d);
        int cyc;
        bit got;
        @(negedge clk);
        preload_addr = a; preload_data = d; preload_we = 1'b1;
        cyc = 0; got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            cyc++;
            got = preload_ack;
        end
        preload_we = 1'b0;
        chk({name, "_ack"}, 32'(got), 32'd1);
        chk({name, "_ackcyc"}, 32'(cyc), 32'd1);
        @(negedge clk);
        chk({name, "_ackpulse"}, 32'(preload_ack), 32'd0);
        chk({name, "_cnts"}, {rd_cnt, wr_cnt}, {m_rd, m_wr});
        mdl[idx(a)] = d; known[idx(a)] = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [15:0] d, a, i10;
        bit ok;
        int k;

        tbl[0] = '{0, 16'h0005, 16'hBEEF, 16'h0000, 16'd0, 16'd0};
        tbl[1] = '{2, 16'h0005, 16'h0000, 16'hBEEF, 16'd1, 16'd0};
        tbl[2] = '{1, 16'h0012, 16'h1234, 16'h0000, 16'd1, 16'd1};
        tbl[3] = '{2, 16'h0012, 16'h0000, 16'h1234, 16'd2, 16'd1};
        tbl[4] = '{2, 16'h0412, 16'h0000, 16'h1234, 16'd3, 16'd1};
        tbl[5] = '{0, 16'h0400, 16'hABCD, 16'h0000, 16'd3, 16'd1};
        tbl[6] = '{2, 16'h0000, 16'h0000, 16'hABCD, 16'd4, 16'd1};
        tbl[7] = '{1, 16'hFFFF, 16'h00FF, 16'h0000, 16'd4, 16'd2};
        tbl[8] = '{2, 16'h03FF, 16'h0000, 16'h00FF, 16'd5, 16'd2};

        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        m_rd = 16'd0; m_wr = 16'd0;
        rst = 1'b1; bus_idle(); preload_we = 1'b0;
        ram_addr = 16'd0; tb_data = 16'd0; preload_addr = 16'd0; preload_data = 16'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_state", 32'(state_out), 32'd0);
        chk("reset_outs", {29'd0, drive_en, preload_ack, bus_conflict}, 32'd0);
        chk("reset_cnts", {rd_cnt, wr_cnt}, 32'd0);

        for (int v = 0; v < 9; v++) begin
            case (tbl[v].op)
                0: op_preload($sformatf("tbl%0d_pre", v), tbl[v].addr, tbl[v].data);
                1: op_write($sformatf("tbl%0d_wr", v), tbl[v].addr, tbl[v].data, 2);
                default: begin
                    op_read($sformatf("tbl%0d_rd", v), tbl[v].addr, d);
                    chk($sformatf("tbl%0d_vec", v), 32'(d), 32'(tbl[v].exp_data));
                end
            endcase
            chk($sformatf("tbl%0d_cnts", v), {rd_cnt, wr_cnt}, {tbl[v].exp_rd, tbl[v].exp_wr});
        end

        op_abort("abort", 16'h0012, 16'h5555);
        op_read("abort_keep", 16'h0012, d);

        @(negedge clk);
        ram_addr = 16'h0005; ram_en = 1'b0; ram_oe = 1'b0;
        @(negedge clk);
        chk("rdwait_state", 32'(state_out), 32'd1);
        ram_oe = 1'b1; ram_en = 1'b1;
        #1 chk("rdwait_nodrive", 32'(drive_en), 32'd0);
        @(negedge clk);
        chk("rdwait_abort", {13'd0, state_out, rd_cnt}, {16'd0, m_rd});

        @(negedge clk);
        ram_addr = 16'h0005; ram_en = 1'b0; ram_oe = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < RD_LAT + 4 && !ok; i++) begin
            @(negedge clk);
            ok = drive_en;
        end
        m_rd = m_rd + 16'd1;
        chk("stream_first", {15'd0, ok, ram_data}, {16'd1, 16'hBEEF});
        ram_addr = 16'h0012;
        #1 chk("stream_hold", 32'(ram_data), 32'h0000BEEF);
        @(negedge clk);
        chk("stream_next", 32'(ram_data), 32'h00001234);
        chk("stream_rdcnt", 32'(rd_cnt), 32'(m_rd));
        ram_oe = 1'b1;
        @(negedge clk);
        ram_en = 1'b1;

        op_preload("relatch_pre", 16'h0020, 16'hAAAA);
        @(negedge clk);
        ram_addr = 16'h0020; tb_data = 16'h1111; tb_drv = 1'b1; ram_en = 1'b0; ram_we = 1'b0;
        @(negedge clk);
        ram_addr = 16'h0021; tb_data = 16'h2222;
        @(negedge clk);
        ram_we = 1'b1; tb_drv = 1'b0;
        @(negedge clk);
        ram_en = 1'b1;
        mdl[idx(16'h0021)] = 16'h2222; known[idx(16'h0021)] = 1'b1;
        m_wr = m_wr + 16'd1;
        chk("relatch_wrcnt", 32'(wr_cnt), 32'(m_wr));
        op_read("relatch_old", 16'h0020, d);
        op_read("relatch_new", 16'h0021, d);

        op_preload("rej_init", 16'h0030, 16'h0101);
        @(negedge clk);
        ram_en = 1'b0;
        preload_addr = 16'h0030; preload_data = 16'h7777; preload_we = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rej_noack", 32'(preload_ack), 32'd0);
        end
        op_read("rej_nochange", 16'h0030, d);
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            ok = preload_ack;
        end
        preload_we = 1'b0;
        chk("rej_lateack", 32'(ok), 32'd1);
        mdl[idx(16'h0030)] = 16'h7777;
        op_read("rej_applied", 16'h0030, d);

        @(negedge clk);
        ram_addr = 16'h0012; tb_data = 16'h9999; tb_drv = 1'b1; ram_en = 1'b0; ram_we = 1'b0;
        @(negedge clk);
        ram_oe = 1'b0;
        @(negedge clk);
        chk("conf_flag", {29'd0, bus_conflict, drive_en, 1'b0}, {29'd0, 3'b100});
        chk("conf_state", 32'(state_out), 32'd0);
        ram_oe = 1'b1; ram_we = 1'b1; tb_drv = 1'b0;
        @(negedge clk);
        ram_en = 1'b1;
        @(negedge clk);
        chk("conf_nowrite", 32'(wr_cnt), 32'(m_wr));
        chk("conf_sticky", 32'(bus_conflict), 32'd1);
        op_read("conf_keep", 16'h0012, d);

        for (int it = 0; it < 300; it++) begin
            k = $urandom_range(0, 3);
            i10 = 16'($urandom_range(0, 31) * 31);
            a = {6'($urandom), i10[9:0]};
            case (k)
                0: if (known[idx(a)]) op_read("rnd_rd", a, d);
                   else op_write("rnd_wr0", a, 16'($urandom), 1);
                1: op_write("rnd_wr", a, 16'($urandom), $urandom_range(1, 3));
                2: op_preload("rnd_pre", a, 16'($urandom));
                default: op_abort("rnd_abort", a, 16'($urandom));
            endcase
        end
        chk("rnd_sticky", 32'(bus_conflict), 32'd1);

        @(negedge clk);
        force dut.wr_cnt_q = 16'hFFFD;
        @(negedge clk);
        release dut.wr_cnt_q;
        m_wr = 16'hFFFD;
        op_write("wrap1", 16'h0040, 16'h0001, 1);
        op_write("wrap2", 16'h0041, 16'h0002, 1);
        op_write("wrap3", 16'h0042, 16'h0003, 1);
        chk("wrap_zero", 32'(wr_cnt), 32'd0);

        @(negedge clk);
        ram_addr = 16'h0005; ram_en = 1'b0; ram_oe = 1'b0;
        @(negedge clk);
        chk("rst_rdwait_pre", 32'(state_out), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_state", 32'(state_out), 32'd0);
        chk("rst_async_outs", {29'd0, drive_en, preload_ack, bus_conflict}, 32'd0);
        chk("rst_async_cnts", {rd_cnt, wr_cnt}, 32'd0);
        bus_idle();
        @(negedge clk);
        rst = 1'b0;
        m_rd = 16'd0; m_wr = 16'd0;

        @(negedge clk);
        ram_addr = 16'h0005; ram_en = 1'b0; ram_oe = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < RD_LAT + 4 && !ok; i++) begin
            @(negedge clk);
            ok = drive_en;
        end
        chk("rst_drive_pre", 32'(ok), 32'd1);
        rst = 1'b1;
        #1 chk("rst_drive_release", 32'(drive_en), 32'd0);
        bus_idle();
        @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        ram_addr = 16'h0012; tb_data = 16'hDEAD; tb_drv = 1'b1; ram_en = 1'b0; ram_we = 1'b0;
        @(negedge clk);
        chk("rst_wr_armed", 32'(state_out), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        ram_we = 1'b1; tb_drv = 1'b0;
        @(negedge clk);
        ram_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wr_drop", 32'(wr_cnt), 32'd0);
        op_read("rst_mem_kept", 16'h0012, d);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
